// File: rtl/mem_pkg.sv
// Shared definitions for the load/store stage: opcodes, FSM states, access sizes,
// byte-enable patterns and the opcode decoder.
package mem_pkg;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  typedef enum logic [1:0] {BYTE, HALF, WORD} size_t;

  // Big-endian lanes: bit 3 of the enable is bits 31:24, i.e. address offset 0.
  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_ALL     = 4'b1111;
  localparam logic [3:0] BE_HI_HALF = 4'b1100;
  localparam logic [3:0] BE_LO_HALF = 4'b0011;
  localparam logic [3:0] BE_LANE0   = 4'b1000;

  typedef struct packed {
    logic  load;
    logic  store;
    size_t size;
    logic  sgn;
  } dec_t;

  function automatic dec_t decode(input logic [5:0] op);
    dec_t d;
    d = '{load: 1'b0, store: 1'b0, size: WORD, sgn: 1'b0};
    case (op)
      OP_LB:   d = '{load: 1'b1, store: 1'b0, size: BYTE, sgn: 1'b1};
      OP_LH:   d = '{load: 1'b1, store: 1'b0, size: HALF, sgn: 1'b1};
      OP_LW:   d = '{load: 1'b1, store: 1'b0, size: WORD, sgn: 1'b0};
      OP_LBU:  d = '{load: 1'b1, store: 1'b0, size: BYTE, sgn: 1'b0};
      OP_LHU:  d = '{load: 1'b1, store: 1'b0, size: HALF, sgn: 1'b0};
      OP_SB:   d = '{load: 1'b0, store: 1'b1, size: BYTE, sgn: 1'b0};
      OP_SH:   d = '{load: 1'b0, store: 1'b1, size: HALF, sgn: 1'b0};
      OP_SW:   d = '{load: 1'b0, store: 1'b1, size: WORD, sgn: 1'b0};
      default: d = '{load: 1'b0, store: 1'b0, size: WORD, sgn: 1'b0};
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic: store steering and byte enables, load extraction with
// sign/zero extension, and misalignment detection (big-endian byte order).
module mem_lane_align
  import mem_pkg::*;
(
  input  size_t       size,
  input  logic        sgn,
  input  logic        access,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] st_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ldata,
  output logic        misaligned
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    be     = BE_NONE;
    wdata  = '0;
    ldata  = '0;
    byte_v = '0;
    half_v = '0;
    case (size)
      BYTE: begin
        be    = BE_LANE0 >> addr_lo;
        wdata = {4{st_data[7:0]}};
        case (addr_lo)
          2'd0:    byte_v = rdata[31:24];
          2'd1:    byte_v = rdata[23:16];
          2'd2:    byte_v = rdata[15:8];
          default: byte_v = rdata[7:0];
        endcase
        ldata = {{24{sgn & byte_v[7]}}, byte_v};
      end
      HALF: begin
        be     = addr_lo[1] ? BE_LO_HALF : BE_HI_HALF;
        wdata  = {2{st_data[15:0]}};
        half_v = addr_lo[1] ? rdata[15:0] : rdata[31:16];
        ldata  = {{16{sgn & half_v[15]}}, half_v};
      end
      default: begin
        be    = BE_ALL;
        wdata = st_data;
        ldata = rdata;
      end
    endcase
    if (!access) be = BE_NONE;
  end

  assign misaligned = access &&
                      (((size == HALF) && addr_lo[0]) ||
                       ((size == WORD) && (addr_lo != 2'b00)));

endmodule

// File: rtl/mem_access.sv
// Load/store stage: one single-beat memory request per memory instruction, one result
// pulse per instruction. Optional ack watchdog under MEM_TIMEOUT_EN.
module mem_access
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_alu,
  input  logic [31:0] in_rt,
  input  logic [31:0] in_insn,
  input  logic [4:0]  in_dest,
  input  logic        in_regwr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic [4:0]  out_dest,
  output logic        out_regwr,
  output logic        out_err,
  output logic [31:0] out_err_pc
);

  state_t      state, state_nx;
  logic [5:0]  op_q;
  logic [1:0]  lo_q;
  logic [31:0] pc_q;
  logic [4:0]  dest_q;
  logic [31:0] res_data;
  logic        res_err, res_regwr;

  dec_t        dec_in, dec_q, dec_a;
  logic [1:0]  lo_a;
  logic        idle, access_a, mis_a, go_mem, timeout;
  logic [3:0]  be_a;
  logic [31:0] wdata_a, ldata_a;

  assign idle     = (state == IDLE);
  assign in_ready = idle;
  assign dec_in   = decode(in_insn[31:26]);
  assign dec_q    = decode(op_q);

  // In IDLE the lane logic serves the incoming instruction; otherwise the captured one.
  assign dec_a    = idle ? dec_in : dec_q;
  assign lo_a     = idle ? in_alu[1:0] : lo_q;
  assign access_a = dec_a.load | dec_a.store;
  assign go_mem   = access_a & ~mis_a;

  mem_lane_align u_align (
    .size       (dec_a.size),
    .sgn        (dec_a.sgn),
    .access     (access_a),
    .addr_lo    (lo_a),
    .st_data    (in_rt),
    .rdata      (mem_rdata),
    .be         (be_a),
    .wdata      (wdata_a),
    .ldata      (ldata_a),
    .misaligned (mis_a)
  );

`ifdef MEM_TIMEOUT_EN
  logic [15:0] wait_cnt;

  assign timeout = (state == REQ) && !mem_ack &&
                   (wait_cnt == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)                       wait_cnt <= '0;
    else if (state != REQ)             wait_cnt <= '0;
    else if (!mem_ack)                 wait_cnt <= wait_cnt + 16'd1;
  end
`else
  logic unused_cfg;
  assign timeout    = 1'b0;
  assign unused_cfg = ^TIMEOUT_CYCLES;
`endif

  logic unused_insn;
  assign unused_insn = ^in_insn[25:0];

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = go_mem ? REQ : DONE;
      REQ:     if (mem_ack || timeout) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      op_q       <= '0;
      lo_q       <= '0;
      pc_q       <= '0;
      dest_q     <= '0;
      res_data   <= '0;
      res_err    <= 1'b0;
      res_regwr  <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= '0;
      mem_wdata  <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_dest   <= '0;
      out_regwr  <= 1'b0;
      out_err    <= 1'b0;
      out_err_pc <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: if (in_valid) begin
          op_q   <= in_insn[31:26];
          lo_q   <= in_alu[1:0];
          pc_q   <= in_pc;
          dest_q <= in_dest;
          if (go_mem) begin
            mem_req   <= 1'b1;
            mem_we    <= dec_in.store;
            mem_addr  <= {in_alu[31:2], 2'b00};
            mem_be    <= be_a;
            mem_wdata <= dec_in.store ? wdata_a : '0;
            res_data  <= '0;
            res_err   <= 1'b0;
            res_regwr <= dec_in.load & in_regwr;
          end else if (access_a) begin
            res_data  <= '0;
            res_err   <= 1'b1;
            res_regwr <= 1'b0;
          end else begin
            res_data  <= in_alu;
            res_err   <= 1'b0;
            res_regwr <= in_regwr;
          end
        end
        REQ: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (dec_q.load) res_data <= ldata_a;
          end else if (timeout) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            res_err   <= 1'b1;
            res_regwr <= 1'b0;
          end
        end
        DONE: begin
          out_valid <= 1'b1;
          out_data  <= res_data;
          out_dest  <= dest_q;
          out_regwr <= res_regwr;
          out_err   <= res_err;
          if (res_err) out_err_pc <= pc_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: expected results are queued at issue and checked
// when out_valid pulses; memory-side signals are checked while mem_req is high.
module tb_mem_access;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = '0, in_alu = '0, in_rt = '0, in_insn = '0;
  logic [4:0]  in_dest = '0;
  logic        in_regwr = 1'b0;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        out_valid, out_regwr, out_err;
  logic [31:0] out_data, out_err_pc;
  logic [4:0]  out_dest;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  dest;
    logic        regwr;
    logic        err;
    logic [31:0] pc;
    logic        dck;
  } exp_t;
  exp_t sb[$];

  mem_access dut (
    .clock(clock), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_alu(in_alu),
    .in_rt(in_rt), .in_insn(in_insn), .in_dest(in_dest), .in_regwr(in_regwr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_data(out_data), .out_dest(out_dest),
    .out_regwr(out_regwr), .out_err(out_err), .out_err_pc(out_err_pc)
  );

  always #5 clock = ~clock;

  task chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // ack_delay < 0: no memory request expected. Latency counts negedges after accept.
  task automatic run(input string name, input logic [31:0] pc, input logic [31:0] alu,
                     input logic [31:0] rt, input logic [5:0] op, input logic [4:0] dest,
                     input logic regwr, input int ack_delay, input logic [31:0] rdata,
                     input logic [31:0] e_addr, input logic [3:0] e_be,
                     input logic [31:0] e_wdata, input logic e_we,
                     input logic [31:0] e_data, input logic e_regwr, input logic e_err,
                     input int e_lat);
    exp_t e, o;
    int n, w;
    logic saw_req, got;
    e = '{data: e_data, dest: dest, regwr: e_regwr, err: e_err, pc: pc, dck: !e_we};
    sb.push_back(e);
    w = 0;
    @(negedge clock);
    while (!in_ready && w < 50) begin @(negedge clock); w++; end
    chk({name, "_in_ready"}, in_ready, 1'b1);
    in_pc = pc; in_alu = alu; in_rt = rt; in_dest = dest; in_regwr = regwr;
    in_insn = {op, 26'($urandom)};
    in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    in_alu = $urandom; in_rt = $urandom; in_insn = $urandom;
    n = 0; saw_req = 1'b0; got = 1'b0;
    while (!got && n < 200) begin
      @(negedge clock); n++;
      if (mem_req) begin
        saw_req = 1'b1;
        chk({name, "_busy"}, in_ready, 1'b0);
        chk({name, "_addr"}, mem_addr, e_addr);
        chk({name, "_be"}, 32'(mem_be), 32'(e_be));
        chk({name, "_we"}, mem_we, e_we);
        if (e_we) chk({name, "_wdata"}, mem_wdata, e_wdata);
        if (n == ack_delay + 1) begin
          mem_ack = 1'b1; mem_rdata = rdata;
          @(posedge clock); #1;
          mem_ack = 1'b0; mem_rdata = $urandom;
        end
      end
      if (out_valid) got = 1'b1;
    end
    chk({name, "_latency"}, n, e_lat);
    chk({name, "_req_seen"}, saw_req, (ack_delay >= 0));
    o = sb.pop_front();
    if (got) begin
      if (o.dck) chk({name, "_data"}, out_data, o.data);
      chk({name, "_dest"}, 32'(out_dest), 32'(o.dest));
      chk({name, "_regwr"}, out_regwr, o.regwr);
      chk({name, "_err"}, out_err, o.err);
      if (o.err) chk({name, "_err_pc"}, out_err_pc, o.pc);
    end
  endtask

  initial begin
    int nv;
    #12;
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_be", 32'(mem_be), 32'h0);
    chk("rst_out_err", out_err, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    @(negedge clock); resetn = 1'b1;

    //  name     pc          alu           rt            op         dst reg dly rdata         addr         be       wdata         we   data          rw   err lat
    run("add",   32'h0100, 32'h0000_1234, 32'h0,        6'b000000, 5'd3, 1, -1, 32'h0,        32'h0,     4'b0000, 32'h0,        0, 32'h0000_1234, 1, 0, 2);
    run("lb",    32'h0104, 32'h0000_0101, 32'h0,        6'b100000, 5'd4, 1,  0, 32'h11F2_3344, 32'h100,   4'b0100, 32'h0,        0, 32'hFFFF_FFF2, 1, 0, 3);
    run("lbu",   32'h0108, 32'h0000_0101, 32'h0,        6'b100100, 5'd5, 1,  0, 32'h11F2_3344, 32'h100,   4'b0100, 32'h0,        0, 32'h0000_00F2, 1, 0, 3);
    run("sh",    32'h010C, 32'h0000_0202, 32'h0000_ABCD, 6'b101001, 5'd6, 1,  1, 32'h0,        32'h200,   4'b0011, 32'hABCD_ABCD, 1, 32'h0,        0, 0, 4);
    run("lw_mis",32'h0400, 32'h0000_0006, 32'h0,        6'b100011, 5'd7, 1, -1, 32'h0,        32'h0,     4'b0000, 32'h0,        0, 32'h0,         0, 1, 2);
    run("lw_d5", 32'h0110, 32'h0000_0080, 32'h0,        6'b100011, 5'd8, 1,  5, 32'hDEAD_BEEF, 32'h80,    4'b1111, 32'h0,        0, 32'hDEAD_BEEF, 1, 0, 8);
    run("lh",    32'h0114, 32'h0000_0102, 32'h0,        6'b100001, 5'd9, 1,  2, 32'h1234_8001, 32'h100,   4'b0011, 32'h0,        0, 32'hFFFF_8001, 1, 0, 5);
    run("lhu",   32'h0118, 32'h0000_1000, 32'h0,        6'b100101, 5'd10,1,  0, 32'h8001_0000, 32'h1000,  4'b1100, 32'h0,        0, 32'h0000_8001, 1, 0, 3);
    run("sb",    32'h011C, 32'h0000_0003, 32'h1234_565A, 6'b101000, 5'd11,1,  0, 32'h0,        32'h0,     4'b0001, 32'h5A5A_5A5A, 1, 32'h0,        0, 0, 3);
    run("sw",    32'h0120, 32'h0000_0010, 32'hCAFE_F00D, 6'b101011, 5'd12,0,  3, 32'h0,        32'h10,    4'b1111, 32'hCAFE_F00D, 1, 32'h0,        0, 0, 6);
    run("lh_mis",32'h0500, 32'h0000_0101, 32'h0,        6'b100001, 5'd13,1, -1, 32'h0,        32'h0,     4'b0000, 32'h0,        0, 32'h0,         0, 1, 2);
    run("sw_mis",32'h0504, 32'h0000_0012, 32'h0,        6'b101011, 5'd14,0, -1, 32'h0,        32'h0,     4'b0000, 32'h0,        0, 32'h0,         0, 1, 2);
    run("pass",  32'h0124, 32'h8000_0000, 32'h0,        6'b111111, 5'd15,0, -1, 32'h0,        32'h0,     4'b0000, 32'h0,        0, 32'h8000_0000, 0, 0, 2);

    // Reset while a load waits for its ack: request drops at once, result is discarded.
    @(negedge clock);
    in_alu = 32'h40; in_insn = {6'b100011, 26'h0}; in_regwr = 1'b1; in_valid = 1'b1;
    @(posedge clock); #1; in_valid = 1'b0;
    @(negedge clock);
    chk("rst_mid_req_up", mem_req, 1'b1);
    @(negedge clock); #2;
    resetn = 1'b0; #1;
    chk("rst_mid_req_drop", mem_req, 1'b0);
    chk("rst_mid_ready", in_ready, 1'b1);
    @(negedge clock); resetn = 1'b1;
    nv = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (out_valid) nv++;
      if (i == 2) mem_ack = 1'b1;
      if (i == 3) mem_ack = 1'b0;
    end
    chk("rst_no_out_valid", nv, 0);
    chk("stray_ack_no_req", mem_req, 1'b0);
    chk("rst_after_ready", in_ready, 1'b1);
    run("post_rst", 32'h0200, 32'h0000_5678, 32'h0, 6'b001000, 5'd1, 1, -1, 32'h0, 32'h0, 4'b0000, 32'h0, 0, 32'h0000_5678, 1, 0, 2);

`ifdef MEM_TIMEOUT_EN
    run("timeout", 32'h0600, 32'h0000_0020, 32'h0, 6'b100011, 5'd2, 1, 1000, 32'h0, 32'h20, 4'b1111, 32'h0, 0, 32'h0, 0, 1, 64 + 2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
